// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance-counter controller.
package perf_pkg;

  localparam int unsigned NUM_CNT_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 32;

  // Command opcodes; 6 and 7 decode as NOP.
  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_START     = 3'd1,
    OP_STOP      = 3'd2,
    OP_CLEAR     = 3'd3,
    OP_SNAP      = 3'd4,
    OP_CLEAR_ONE = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SNAP = 2'd2
  } state_e;

endpackage

// File: rtl/perf_counter.sv
// One event counter with enable, synchronous clear and sticky wrap flag.
//   clk, rst   clock, async active-low reset
//   en         increment this cycle
//   clr        zero the count and the overflow flag (wins over en)
//   count      current count, modulo 2^CNT_W
//   ovf        set on wrap from all-ones, held until clr
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      count <= count + CNT_W'(1);
      if (&count) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance-counter controller: command FSM, counter bank, snapshot
// shadow bank and a valid/ready read port serving the shadows.
//   clk, rst                 clock, async active-low reset
//   event_i                  per-counter increment condition
//   cmd_valid/ready/op/sel   command port (start/stop/clear/snap/clear_one)
//   rd_req_valid/ready/sel   read request into the shadow bank
//   rd_resp_valid/ready/data read response, one outstanding
//   running                  counters enabled
//   overflow                 sticky per-counter wrap flags
module perf_counter_ctrl
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT = NUM_CNT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned SEL_W   = $clog2(NUM_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [SEL_W-1:0]   cmd_sel,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [SEL_W-1:0]   rd_req_sel,
  output logic               rd_resp_valid,
  input  logic               rd_resp_ready,
  output logic [CNT_W-1:0]   rd_resp_data,
  output logic               running,
  output logic [NUM_CNT-1:0] overflow
);

  state_e           state, next_state;
  logic             run_q, next_run;
  logic             cmd_fire_c;
  logic             snap_c, clr_all_c, clr_one_c;
  logic             cnt_en_c;
  logic             rd_fire_c;
  logic [CNT_W-1:0] rd_data_c;
  logic [CNT_W-1:0] cnt    [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];

  assign cmd_fire_c = cmd_valid && cmd_ready;
  // SNAP with run_q set keeps counting so a snapshot never costs a cycle.
  assign cnt_en_c   = (state == ST_RUN) || ((state == ST_SNAP) && run_q);

  // FSM state register and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      run_q     <= 1'b0;
      cmd_ready <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= next_state;
      run_q     <= next_run;
      cmd_ready <= (next_state != ST_SNAP);
      running   <= next_run;
    end
  end

  // Next state and command decode.
  always_comb begin
    next_state = state;
    next_run   = run_q;
    snap_c     = 1'b0;
    clr_all_c  = 1'b0;
    clr_one_c  = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (cmd_fire_c) begin
          case (cmd_op_e'(cmd_op))
            OP_START: begin
              next_state = ST_RUN;
              next_run   = 1'b1;
            end
            OP_STOP: begin
              next_state = ST_IDLE;
              next_run   = 1'b0;
            end
            OP_CLEAR:     clr_all_c = 1'b1;
            OP_CLEAR_ONE: clr_one_c = 1'b1;
            OP_SNAP: begin
              snap_c     = 1'b1;
              next_state = ST_SNAP;
            end
            default: ;
          endcase
        end
      end
      ST_SNAP: next_state = run_q ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Counter bank; an out-of-range cmd_sel matches no instance.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic clr_c;
    assign clr_c = clr_all_c || (clr_one_c && (cmd_sel == SEL_W'(i)));
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (cnt_en_c && event_i[i]),
      .clr   (clr_c),
      .count (cnt[i]),
      .ovf   (overflow[i])
    );
  end

  // Shadow bank captures every counter on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (snap_c) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= cnt[i];
    end
  end

  // Shadow select; indices past the bank read as zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_req_sel == SEL_W'(i)) rd_data_c = shadow[i];
    end
  end

  assign rd_req_ready = !rd_resp_valid || rd_resp_ready;
  assign rd_fire_c    = rd_req_valid && rd_req_ready;

  // Response register; data only moves on an accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else if (rd_fire_c) begin
      rd_resp_valid <= 1'b1;
      rd_resp_data  <= rd_data_c;
    end else if (rd_resp_ready) begin
      rd_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl (4 counters, 8-bit, 3-bit selects).
module tb_perf_counter_ctrl;

  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [2:0] NOP = 3'd0, START = 3'd1, STOP = 3'd2,
                         CLEAR = 3'd3, SNAP = 3'd4, CLEAR_ONE = 3'd5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_CNT-1:0] event_i;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [SEL_W-1:0]   cmd_sel;
  logic               rd_req_valid;
  logic               rd_req_ready;
  logic [SEL_W-1:0]   rd_req_sel;
  logic               rd_resp_valid;
  logic               rd_resp_ready;
  logic [CNT_W-1:0]   rd_resp_data;
  logic               running;
  logic [NUM_CNT-1:0] overflow;

  int n_checks = 0;
  int n_errors = 0;

  perf_counter_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .event_i       (event_i),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_sel       (cmd_sel),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_sel    (rd_req_sel),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .running       (running),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command; waits a bounded time for cmd_ready.
  task automatic cmd(input logic [2:0] op, input logic [SEL_W-1:0] sel);
    int n = 0;
    while (!cmd_ready && n < 10) begin
      tick(1);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    tick(1);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_sel   = '0;
  endtask

  // Single read with rd_resp_ready high; checks valid and data.
  task automatic rd_chk(input string tag, input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] exp);
    rd_resp_ready = 1'b1;
    rd_req_valid  = 1'b1;
    rd_req_sel    = sel;
    tick(1);
    rd_req_valid  = 1'b0;
    check({tag, "_valid"}, 32'(rd_resp_valid), 32'd1);
    check(tag, 32'(rd_resp_data), 32'(exp));
  endtask

  task automatic snap_settle();
    cmd(SNAP, '0);
    tick(1);
  endtask

  initial begin
    rst           = 1'b0;
    event_i       = '0;
    cmd_valid     = 1'b0;
    cmd_op        = NOP;
    cmd_sel       = '0;
    rd_req_valid  = 1'b0;
    rd_req_sel    = '0;
    rd_resp_ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_rd_req_ready", 32'(rd_req_ready), 32'd1);
    check("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
    check("rst_resp_data", 32'(rd_resp_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    tick(1);

    // Cycle counting: 10 events on counter 0
    cmd(START, '0);
    check("start_running", 32'(running), 32'd1);
    event_i = 4'b0001;
    tick(10);
    event_i = '0;
    cmd(STOP, '0);
    check("stop_running", 32'(running), 32'd0);
    cmd(SNAP, '0);
    check("snap_cmd_ready_low", 32'(cmd_ready), 32'd0);
    tick(1);
    check("snap_cmd_ready_back", 32'(cmd_ready), 32'd1);
    rd_chk("cnt0_10", 3'd0, 8'd10);
    rd_chk("cnt1_0", 3'd1, 8'd0);
    rd_chk("cnt2_0", 3'd2, 8'd0);
    rd_chk("cnt3_0", 3'd3, 8'd0);

    // Wrap: 300 events on an 8-bit counter
    cmd(START, '0);
    event_i = 4'b0010;
    tick(300);
    event_i = '0;
    cmd(STOP, '0);
    snap_settle();
    check("wrap_ovf", 32'(overflow), 32'h2);
    rd_chk("wrap_cnt1", 3'd1, 8'd44);
    rd_chk("wrap_cnt0", 3'd0, 8'd10);
    cmd(CLEAR_ONE, 3'd4);
    check("clr_one_oob_ovf", 32'(overflow), 32'h2);
    cmd(CLEAR_ONE, 3'd1);
    check("clr_one_ovf", 32'(overflow), 32'h0);
    snap_settle();
    rd_chk("clr_one_cnt1", 3'd1, 8'd0);
    rd_chk("clr_one_cnt0", 3'd0, 8'd10);

    // Snapshot atomicity during RUN, all events high
    cmd(CLEAR, '0);
    cmd(START, '0);
    event_i = 4'hF;
    tick(5);
    cmd(SNAP, '0);
    check("atom_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("atom_running", 32'(running), 32'd1);
    tick(1);
    check("atom_cmd_ready_back", 32'(cmd_ready), 32'd1);
    check("atom_back_to_run", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) rd_chk("atom_shadow", 3'(i), 8'd5);
    event_i = '0;
    cmd(STOP, '0);
    snap_settle();
    rd_chk("atom_count_thru_snap", 3'd0, 8'd11);

    // CLEAR in the same cycle as an increment
    cmd(CLEAR, '0);
    cmd(START, '0);
    event_i = 4'b0001;
    tick(3);
    cmd(CLEAR, '0);
    event_i = '0;
    check("clr_keeps_run", 32'(running), 32'd1);
    cmd(STOP, '0);
    snap_settle();
    rd_chk("clr_vs_inc", 3'd0, 8'd0);

    // Read accepted on the same edge as SNAP returns the old shadow
    cmd(START, '0);
    event_i = 4'b0011;
    tick(3);
    event_i = 4'b0001;
    tick(2);
    event_i = '0;
    cmd(STOP, '0);
    rd_resp_ready = 1'b1;
    rd_req_valid  = 1'b1;
    rd_req_sel    = 3'd0;
    cmd_valid     = 1'b1;
    cmd_op        = SNAP;
    tick(1);
    cmd_valid     = 1'b0;
    cmd_op        = NOP;
    rd_req_valid  = 1'b0;
    check("rd_snap_valid", 32'(rd_resp_valid), 32'd1);
    check("rd_snap_old", 32'(rd_resp_data), 32'd0);
    tick(1);
    rd_chk("rd_snap_new0", 3'd0, 8'd5);
    rd_chk("rd_snap_new1", 3'd1, 8'd3);
    tick(1);

    // Backpressure on the read response
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_sel    = 3'd0;
    tick(1);
    rd_req_sel = 3'd1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(rd_resp_valid), 32'd1);
      check("bp_data_stable", 32'(rd_resp_data), 32'd5);
      check("bp_req_ready_low", 32'(rd_req_ready), 32'd0);
      if (i < 2) tick(1);
    end
    rd_resp_ready = 1'b1;
    #1;
    check("bp_req_ready_high", 32'(rd_req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_next_valid", 32'(rd_resp_valid), 32'd1);
    check("bp_next_data", 32'(rd_resp_data), 32'd3);
    rd_req_sel = 3'd5;
    tick(1);
    check("oob_sel_data", 32'(rd_resp_data), 32'd0);
    rd_req_valid = 1'b0;
    tick(1);
    check("resp_drained", 32'(rd_resp_valid), 32'd0);

    // Asynchronous reset mid-RUN with a wrap flag and a pending response
    cmd(START, '0);
    event_i = 4'b0100;
    tick(256);
    event_i = '0;
    check("pre_rst_ovf", 32'(overflow), 32'h4);
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_sel    = 3'd0;
    tick(1);
    rd_req_valid = 1'b0;
    check("pre_rst_pending", 32'(rd_resp_valid), 32'd1);
    check("pre_rst_running", 32'(running), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_running", 32'(running), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_resp_valid", 32'(rd_resp_valid), 32'd0);
    check("arst_resp_data", 32'(rd_resp_data), 32'd0);
    check("arst_rd_req_ready", 32'(rd_req_ready), 32'd1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rd_chk("arst_shadow0", 3'd0, 8'd0);
    check("arst_idle", 32'(running), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
